// File: rtl/block_row_drawer.sv
// Rasterises a horizontal row of BLOCK_SIZE x BLOCK_SIZE blocks into one VGA pixel write per clock.
// Latency: first pixel one edge after start, done one edge after the last pixel; start is ignored while busy.
module block_row_drawer #(
  parameter int BLOCK_SIZE = 4,
  parameter int MAX_BLOCKS = 8,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic [3:0] num_blocks,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int PX_RAW = $clog2(MAX_BLOCKS * BLOCK_SIZE);
  localparam int PY_RAW = $clog2(BLOCK_SIZE);
  localparam int PXW    = (PX_RAW < 1) ? 1 : PX_RAW;
  localparam int PYW    = (PY_RAW < 1) ? 1 : PY_RAW;
  localparam logic [PYW-1:0] PY_LAST = PYW'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t         state;
  logic [7:0]     x0;
  logic [6:0]     y0;
  logic [2:0]     colour;
  logic [PXW-1:0] px;
  logic [PYW-1:0] py;
  logic [PXW-1:0] px_last;

  logic [3:0]     n_clamped;
  logic [PXW:0]   span;
  logic [8:0]     x_sum;
  logic [7:0]     y_sum;
  logic           on_screen;

  always_comb begin
    n_clamped = (num_blocks > 4'(MAX_BLOCKS)) ? 4'(MAX_BLOCKS) : num_blocks;
    span      = (PXW+1)'(n_clamped) * (PXW+1)'(BLOCK_SIZE);
    // Full-width sums so coordinates past the right/bottom edge clip instead of wrapping.
    x_sum     = {1'b0, x0} + 9'(px);
    y_sum     = {1'b0, y0} + 8'(py);
    on_screen = (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x0         <= '0;
      y0         <= '0;
      colour     <= '0;
      px         <= '0;
      py         <= '0;
      px_last    <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (start) begin
            x0      <= x_in;
            y0      <= y_in;
            colour  <= colour_in;
            px      <= '0;
            py      <= '0;
            px_last <= PXW'(span - 1'b1);
            busy    <= 1'b1;
            state   <= (n_clamped == 4'd0) ? FINISH : DRAW;
          end else begin
            busy <= 1'b0;
          end
        end

        DRAW: begin
          vga_colour <= colour;
          plot       <= on_screen;
          // Suppressed pixels leave the last visible coordinate on the bus.
          if (on_screen) begin
            vga_x <= x_sum[7:0];
            vga_y <= y_sum[6:0];
          end
          if (px == px_last) begin
            px <= '0;
            if (py == PY_LAST) begin
              state <= FINISH;
            end else begin
              py <= py + PYW'(1);
            end
          end else begin
            px <= px + PXW'(1);
          end
        end

        FINISH: begin
          plot  <= 1'b0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          plot  <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_row_drawer.sv
// Bench for block_row_drawer: directed rows, clipping, clamping, reset abort and random rows
// compared pixel by pixel against a row model built from plain arithmetic.
module tb_block_row_drawer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [3:0] num_blocks;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int last_x = 0;
  int last_y = 0;

  block_row_drawer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .num_blocks (num_blocks),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full row: start at edge 0, pixels on edges 1..n*16, done after the following edge.
  // With noise set, inputs and start are scrambled while the row is in flight.
  task automatic run_row(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                         input logic [3:0] nb, input bit noise);
    int n, w, total, ex, ey, idx, plots, vis_x, vis_y;
    bit ep;
    n     = (int'(nb) > 8) ? 8 : int'(nb);
    w     = n * 4;
    total = w * 4;
    x_in = x; y_in = y; colour_in = c; num_blocks = nb; start = 1'b1;
    step();
    start = 1'b0;
    plots = 0;
    for (int k = 1; k <= total; k++) begin
      if (noise) begin
        x_in = 8'($urandom); y_in = 7'($urandom); colour_in = 3'($urandom);
        num_blocks = 4'($urandom); start = 1'($urandom_range(0, 1));
      end
      step();
      idx = k - 1;
      ex  = int'(x) + idx % w;
      ey  = int'(y) + idx / w;
      ep  = (ex < 160) && (ey < 120);
      chk("plot", 32'(plot), 32'(ep));
      chk("busy_draw", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      plots += int'(plot);
      if (ep) begin
        chk("vga_x", 32'(vga_x), ex);
        chk("vga_y", 32'(vga_y), ey);
        chk("vga_colour", 32'(vga_colour), 32'(c));
        last_x = ex;
        last_y = ey;
      end else begin
        chk("hold_x", 32'(vga_x), last_x);
        chk("hold_y", 32'(vga_y), last_y);
      end
    end
    // The FINISH cycle: a start here must be ignored.
    if (noise) start = 1'($urandom_range(0, 1));
    step();
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("plot_at_done", 32'(plot), 32'd0);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("hold_x_done", 32'(vga_x), last_x);
    step();
    chk("done_single", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("plot_idle", 32'(plot), 32'd0);
    vis_x = 160 - int'(x);
    if (vis_x > w) vis_x = w;
    if (vis_x < 0) vis_x = 0;
    vis_y = 120 - int'(y);
    if (vis_y > 4) vis_y = 4;
    if (vis_y < 0) vis_y = 0;
    chk("plot_count", plots, vis_x * vis_y);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; x_in = '0; y_in = '0; colour_in = '0; num_blocks = '0;
    step();
    step();
    chk("rst_x", 32'(vga_x), 0);
    chk("rst_y", 32'(vga_y), 0);
    chk("rst_colour", 32'(vga_colour), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    step();

    run_row(8'd0,   7'd116, 3'b101, 4'd1,  1'b0);
    run_row(8'd152, 7'd100, 3'b010, 4'd3,  1'b0);
    run_row(8'd10,  7'd20,  3'b111, 4'd12, 1'b0);
    run_row(8'd30,  7'd40,  3'b011, 4'd0,  1'b0);
    run_row(8'd50,  7'd60,  3'b110, 4'd2,  1'b1);

    // Reset in the middle of a draw.
    x_in = 8'd20; y_in = 7'd30; colour_in = 3'b100; num_blocks = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) step();
    chk("mid_plot", 32'(plot), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_plot", 32'(plot), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_x", 32'(vga_x), 0);
    chk("abort_y", 32'(vga_y), 0);
    chk("abort_colour", 32'(vga_colour), 0);
    last_x = 0;
    last_y = 0;
    step();
    chk("abort_no_done", 32'(done), 0);

    run_row(8'd8, 7'd0, 3'b000, 4'd2, 1'b0);

    for (int r = 0; r < 30; r++) begin
      run_row(8'($urandom), 7'($urandom), 3'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
